// File: rtl/int_to_fp.sv
// Pipelined signed fixed-point integer to floating-point converter (bfloat16 by default).
// Four register stages: magnitude, leading-one detect, normalize, round-to-nearest-even.
module int_to_fp #(
  parameter int EXPONENT_SIZE        = 8,
  parameter int MANTISSA_SIZE        = 7,
  parameter int INT_SIZE             = 16,
  parameter int FIXED_POINT_POSITION = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INT_SIZE-1:0]      din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sign,
  output logic [EXPONENT_SIZE-1:0] exponent,
  output logic [MANTISSA_SIZE-1:0] mantissa
);
  localparam int BIAS = 2**(EXPONENT_SIZE-1) - 1;
  localparam int PW   = $clog2(INT_SIZE);
  // Selects the bits below the guard bit of a normalized word.
  localparam logic [INT_SIZE-1:0] STICKY_MASK = {INT_SIZE{1'b1}} >> (MANTISSA_SIZE + 2);

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Stage registers
  logic                     s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic                     s1_sign_reg, s2_sign_reg, s3_sign_reg;
  logic [INT_SIZE-1:0]      s1_mag_reg, s2_mag_reg, s3_norm_reg;
  logic [PW-1:0]            s2_lead_reg;
  logic                     s2_zero_reg;
  logic [EXPONENT_SIZE-1:0] s3_exp_reg;

  // S1: magnitude; the most negative input maps to 2**(INT_SIZE-1) unsigned.
  logic [INT_SIZE-1:0] mag_next;
  assign mag_next = din[INT_SIZE-1] ? -din : din;

  // S2: leading-one position (highest set bit wins).
  logic [PW-1:0] lead_next;
  logic          zero_next;
  always_comb begin
    lead_next = '0;
    for (int i = 0; i < INT_SIZE; i++) begin
      if (s1_mag_reg[i]) lead_next = PW'(i);
    end
  end
  assign zero_next = (s1_mag_reg == '0);

  // S3: normalize so the leading one sits in the MSB.
  logic [PW-1:0]            shift_amt;
  logic [INT_SIZE-1:0]      norm_next;
  logic [EXPONENT_SIZE-1:0] exp_next;
  assign shift_amt = PW'(INT_SIZE - 1) - s2_lead_reg;
  assign norm_next = s2_mag_reg << shift_amt;
  assign exp_next  = s2_zero_reg ? '0
                   : EXPONENT_SIZE'(BIAS + int'(s2_lead_reg) - FIXED_POINT_POSITION);

  // S4: round to nearest, ties to even; a zero word has no hidden bit and never rounds.
  logic                     hidden_bit, guard_bit, sticky_bit, round_up;
  logic [MANTISSA_SIZE-1:0] kept;
  logic [MANTISSA_SIZE:0]   rounded;
  logic [EXPONENT_SIZE-1:0] exp_out_next;
  assign hidden_bit   = s3_norm_reg[INT_SIZE-1];
  assign kept         = s3_norm_reg[INT_SIZE-2 -: MANTISSA_SIZE];
  assign guard_bit    = s3_norm_reg[INT_SIZE-2-MANTISSA_SIZE];
  assign sticky_bit   = |(s3_norm_reg & STICKY_MASK);
  assign round_up     = hidden_bit & guard_bit & (sticky_bit | kept[0]);
  assign rounded      = {1'b0, kept} + (MANTISSA_SIZE+1)'(round_up);
  assign exp_out_next = s3_exp_reg + EXPONENT_SIZE'(rounded[MANTISSA_SIZE]);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      out_valid    <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s2_sign_reg  <= 1'b0;
      s3_sign_reg  <= 1'b0;
      s1_mag_reg   <= '0;
      s2_mag_reg   <= '0;
      s2_lead_reg  <= '0;
      s2_zero_reg  <= 1'b0;
      s3_norm_reg  <= '0;
      s3_exp_reg   <= '0;
      sign         <= 1'b0;
      exponent     <= '0;
      mantissa     <= '0;
    end else if (advance) begin
      s1_valid_reg <= in_valid;
      s1_sign_reg  <= din[INT_SIZE-1];
      s1_mag_reg   <= mag_next;

      s2_valid_reg <= s1_valid_reg;
      s2_sign_reg  <= s1_sign_reg;
      s2_mag_reg   <= s1_mag_reg;
      s2_lead_reg  <= lead_next;
      s2_zero_reg  <= zero_next;

      s3_valid_reg <= s2_valid_reg;
      s3_sign_reg  <= s2_sign_reg;
      s3_norm_reg  <= norm_next;
      s3_exp_reg   <= exp_next;

      out_valid    <= s3_valid_reg;
      sign         <= s3_sign_reg;
      exponent     <= exp_out_next;
      mantissa     <= rounded[MANTISSA_SIZE-1:0];
    end
  end
endmodule

// File: tb/tb_int_to_fp.sv
// Bench for int_to_fp: default bfloat16 instance plus a FIXED_POINT_POSITION=8 instance,
// checked against a division-based rounding model.
module tb_int_to_fp;
  localparam int E = 8;
  localparam int M = 7;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, sign;
  logic [W-1:0] din;
  logic [E-1:0] exponent;
  logic [M-1:0] mantissa;

  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, sign_b;
  logic [W-1:0] din_b;
  logic [E-1:0] exponent_b;
  logic [M-1:0] mantissa_b;

  int_to_fp #(.EXPONENT_SIZE(E), .MANTISSA_SIZE(M), .INT_SIZE(W), .FIXED_POINT_POSITION(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .exponent(exponent),
    .mantissa(mantissa));

  int_to_fp #(.EXPONENT_SIZE(E), .MANTISSA_SIZE(M), .INT_SIZE(W), .FIXED_POINT_POSITION(8)) dut_fp (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b), .din(din_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .sign(sign_b), .exponent(exponent_b),
    .mantissa(mantissa_b));

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];  // {din, expected {sign, exponent, mantissa}}
  logic [15:0] held;
  logic        held_v = 1'b0;

  // value = v * 2**-fpp; mantissa found by exact division and explicit RNE.
  function automatic logic [15:0] model(input int v, input int fpp);
    longint mag, num, den, q, r;
    int e;
    logic s;
    if (v == 0) return 16'h0000;
    s = (v < 0);
    mag = s ? -longint'(v) : longint'(v);
    e = 0;
    while ((longint'(1) << (e + 1)) <= mag) e++;
    num = mag << M;
    den = longint'(1) << e;
    q = num / den;
    r = num % den;
    if (2 * r > den || (2 * r == den && (q % 2) == 1)) q++;
    if (q == (longint'(1) << (M + 1))) begin
      q = longint'(1) << M;
      e++;
    end
    return {s, 8'(127 + e - fpp), 7'(q - (longint'(1) << M))};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock of the default instance: drive, sample before the edge, score handshakes.
  task automatic cycle(input logic iv, input logic [15:0] d, input logic ordy, input logic [15:0] expv);
    logic [15:0] obs;
    logic [31:0] ent;
    @(negedge clk);
    in_valid = iv;
    din = d;
    out_ready = ordy;
    #1;
    obs = {sign, exponent, mantissa};
    check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
    if (held_v) check("stall_hold", {15'd0, out_valid, obs}, {15'd0, 1'b1, held});
    held_v = out_valid && !out_ready;
    held = obs;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        ent = exp_q.pop_front();
        check("result", 32'(obs), 32'(ent[15:0]));
        $display("[TB] din=%0d -> sign=%0d exp=%0d mant=0x%h", $signed(ent[31:16]),
                 sign, exponent, mantissa);
      end
    end
    if (iv && in_ready) exp_q.push_back({d, expv});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      cycle(1'b0, 16'h0000, 1'b1, 16'h0000);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Reset is asserted together with a valid input, which must be dropped.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    din = 16'h1234;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_fields", 32'({sign, exponent, mantissa}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    held_v = 1'b0;
  endtask

  logic [15:0] dir_din[8] = '{16'd1, 16'hFFFD, 16'd0, 16'h8000, 16'h7FFF, 16'h0181, 16'h0183, 16'h4000};
  logic [15:0] dir_exp[8] = '{16'h3F80, 16'hC040, 16'h0000, 16'hC700, 16'h4700, 16'h43C0, 16'h43C2, 16'h4680};

  int lat, tries, w;
  logic [15:0] v, fexp;
  logic ordy;

  initial begin
    in_valid = 1'b0; din = '0; out_ready = 1'b1;
    in_valid_b = 1'b0; din_b = '0; out_ready_b = 1'b1;
    do_reset();

    // Latency: presented in one cycle, visible four cycles later.
    cycle(1'b1, 16'd1, 1'b1, 16'h3F80);
    lat = 0;
    do begin
      cycle(1'b0, 16'h0000, 1'b1, 16'h0000);
      lat++;
    end while (!out_valid && lat < 10);
    check("latency", 32'(lat), 32'd4);
    drain();

    // Directed values, back to back.
    for (int i = 0; i < 8; i++) cycle(1'b1, dir_din[i], 1'b1, dir_exp[i]);
    drain();

    // Sequence 1..20 under pseudo-random backpressure.
    for (int k = 1; k <= 20; k++) begin
      tries = 0;
      do begin
        ordy = ($urandom_range(0, 1) == 1);
        cycle(1'b1, 16'(k), ordy, model(k, 0));
        tries++;
      end while (!in_ready && tries < 50);
      check("bp_accept", 32'(in_ready), 32'd1);
    end
    drain();

    // Random values, bubbles and backpressure.
    for (int k = 0; k < 300; k++) begin
      v = 16'($urandom());
      cycle(($urandom_range(0, 3) != 0), v, ($urandom_range(0, 2) != 0), model($signed(v), 0));
    end
    drain();

    // Full-throughput burst.
    for (int k = 0; k < 40; k++) begin
      v = 16'($urandom());
      cycle(1'b1, v, 1'b1, model($signed(v), 0));
      check("full_rate_ready", 32'(in_ready), 32'd1);
    end
    drain();

    // Reset with three samples in flight.
    for (int k = 0; k < 3; k++) cycle(1'b1, 16'(100 + k), 1'b1, model(100 + k, 0));
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 16'h0000, 1'b1, 16'h0000);
      check("post_reset_idle", 32'(out_valid), 32'd0);
    end
    cycle(1'b1, 16'hFFFF, 1'b1, model(-1, 0));
    drain();

    // Fixed-point instance (8 fractional bits).
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        v = 16'h0180;
        fexp = 16'h3FC0;
      end else begin
        v = 16'($urandom());
        fexp = model($signed(v), 8);
      end
      @(negedge clk);
      in_valid_b = 1'b1;
      din_b = v;
      #1;
      check("fp_in_ready", 32'(in_ready_b), 32'd1);
      @(negedge clk);
      in_valid_b = 1'b0;
      #1;
      w = 0;
      while (!out_valid_b && w < 10) begin
        @(negedge clk);
        #1;
        w++;
      end
      check("fp_result", {15'd0, out_valid_b, sign_b, exponent_b, mantissa_b}, {15'd0, 1'b1, fexp});
      $display("[TB] fp din=0x%h -> sign=%0d exp=%0d mant=0x%h", v, sign_b, exponent_b, mantissa_b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
